// File: rtl/coef_mem_banked_if.sv
// Bus bundle for the banked coefficient store: clear control, write port,
// read port and degree register.
interface coef_mem_banked_if #(
  parameter int RAM_WIDTH     = 26,
  parameter int RAM_ADDR_BITS = 11,
  parameter int BANK_BITS     = 1
);
  logic                     clr_start;
  logic                     busy;
  logic                     wr_en;
  logic [BANK_BITS-1:0]     wr_bank;
  logic [RAM_ADDR_BITS-1:0] wr_addr;
  logic [RAM_WIDTH-1:0]     wr_data;
  logic                     wr_err;
  logic                     rd_en;
  logic [BANK_BITS-1:0]     rd_bank;
  logic [RAM_ADDR_BITS-1:0] rd_addr;
  logic [RAM_WIDTH-1:0]     rd_data;
  logic                     rd_valid;
  logic                     deg_we;
  logic [10:0]              deg_in;
  logic [10:0]              deg_out;

  modport master (
    output clr_start, wr_en, wr_bank, wr_addr, wr_data,
           rd_en, rd_bank, rd_addr, deg_we, deg_in,
    input  busy, wr_err, rd_data, rd_valid, deg_out
  );

  modport slave (
    input  clr_start, wr_en, wr_bank, wr_addr, wr_data,
           rd_en, rd_bank, rd_addr, deg_we, deg_in,
    output busy, wr_err, rd_data, rd_valid, deg_out
  );
endinterface

// File: rtl/coef_mem_banked.sv
// Multi-bank distributed coefficient RAM for the SNTRUP757 datapath with
// hardware clear sweep, range-checked ports and a latched degree register.
module coef_mem_banked #(
  parameter int RAM_WIDTH     = 26,
  parameter int RAM_ADDR_BITS = 11,
  parameter int DEPTH         = 757,
  parameter int NBANKS        = 2,
  parameter int REG_OUT       = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  coef_mem_banked_if.slave bus
);
  localparam int BANK_BITS = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam int IDX_BITS  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Limits are one bit wider than the ports so DEPTH == 2**RAM_ADDR_BITS still fits.
  localparam logic [RAM_ADDR_BITS:0]   ADDR_LIM  = (RAM_ADDR_BITS+1)'(DEPTH);
  localparam logic [BANK_BITS:0]       BANK_LIM  = (BANK_BITS+1)'(NBANKS);
  localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR = RAM_ADDR_BITS'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                   state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] cnt_q, cnt_d;
  logic                     wr_err_q, wr_err_d;
  logic [10:0]              deg_q, deg_d;

  logic                     wr_ok;
  logic                     rd_ok;
  logic [RAM_WIDTH-1:0]     rd_word;

  logic [RAM_WIDTH-1:0]     mem [NBANKS][DEPTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    wr_ok = bus.wr_en && (state_q == IDLE)
            && ((BANK_BITS+1)'(bus.wr_bank) < BANK_LIM)
            && ((RAM_ADDR_BITS+1)'(bus.wr_addr) < ADDR_LIM);
    wr_err_d = bus.wr_en && !wr_ok;
    deg_d    = bus.deg_we ? bus.deg_in : deg_q;
    rd_ok    = ((BANK_BITS+1)'(bus.rd_bank) < BANK_LIM)
               && ((RAM_ADDR_BITS+1)'(bus.rd_addr) < ADDR_LIM);
    rd_word  = '0;
    if (rd_ok) begin
      rd_word = mem[bus.rd_bank][bus.rd_addr[IDX_BITS-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_err_q <= 1'b0;
      deg_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_err_q <= wr_err_d;
      deg_q    <= deg_d;
    end
  end

  // Array has no reset; an asserted rst_n freezes contents, aborting any sweep.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == CLEAR) begin
        for (int b = 0; b < NBANKS; b++) begin
          mem[b][cnt_q[IDX_BITS-1:0]] <= '0;
        end
      end else if (wr_ok) begin
        mem[bus.wr_bank][bus.wr_addr[IDX_BITS-1:0]] <= bus.wr_data;
      end
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic                 rd_valid_q, rd_valid_d;
      logic [RAM_WIDTH-1:0] rd_data_q, rd_data_d;

      always_comb begin
        rd_valid_d = bus.rd_en;
        rd_data_d  = bus.rd_en ? rd_word : rd_data_q;
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd_valid_q <= 1'b0;
          rd_data_q  <= '0;
        end else begin
          rd_valid_q <= rd_valid_d;
          rd_data_q  <= rd_data_d;
        end
      end

      assign bus.rd_data  = rd_data_q;
      assign bus.rd_valid = rd_valid_q;
    end else begin : g_comb_out
      assign bus.rd_data  = rd_word;
      assign bus.rd_valid = bus.rd_en;
    end
  endgenerate

  assign bus.busy    = (state_q == CLEAR);
  assign bus.wr_err  = wr_err_q;
  assign bus.deg_out = deg_q;
endmodule

// File: tb/tb_coef_mem_banked.sv
// Randomised scoreboard bench for coef_mem_banked: a per-cycle reference model
// queues expected outputs, and a negedge monitor compares them with the DUT.
module tb_coef_mem_banked;
  localparam int W  = 26;
  localparam int AB = 11;
  localparam int D  = 757;
  localparam int NB = 2;

  typedef struct packed {
    logic         busy;
    logic         wr_err;
    logic         rd_valid;
    logic [W-1:0] rd_data;
    logic [10:0]  deg_out;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   errors  = 0;

  exp_t         exp_q[$];
  logic [W-1:0] model [NB][D];
  bit           sweeping = 1'b0;
  int           sweep_idx = 0;
  logic [W-1:0] last_rd = '0;
  logic [10:0]  deg_m = '0;

  coef_mem_banked_if #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB), .BANK_BITS(1)) bus ();

  coef_mem_banked #(
    .RAM_WIDTH(W), .RAM_ADDR_BITS(AB), .DEPTH(D), .NBANKS(NB), .REG_OUT(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: every post-edge expectation is compared half a cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("busy",     32'(bus.busy),     32'(e.busy));
      check("wr_err",   32'(bus.wr_err),   32'(e.wr_err));
      check("rd_valid", 32'(bus.rd_valid), 32'(e.rd_valid));
      check("rd_data",  32'(bus.rd_data),  32'(e.rd_data));
      check("deg_out",  32'(bus.deg_out),  32'(e.deg_out));
    end
  end

  task automatic apply_stimulus(input bit rstn_i, input bit clr_i,
                                input bit we_i, input int wb_i, input int wa_i,
                                input logic [W-1:0] wd_i,
                                input bit re_i, input int rb_i, input int ra_i,
                                input bit dwe_i, input logic [10:0] din_i);
    exp_t e;
    bit   w_ok;
    rst_n         = rstn_i;
    bus.clr_start = clr_i;
    bus.wr_en     = we_i;
    bus.wr_bank   = 1'(wb_i);
    bus.wr_addr   = AB'(wa_i);
    bus.wr_data   = wd_i;
    bus.rd_en     = re_i;
    bus.rd_bank   = 1'(rb_i);
    bus.rd_addr   = AB'(ra_i);
    bus.deg_we    = dwe_i;
    bus.deg_in    = din_i;
    e = '0;
    if (!rstn_i) begin
      sweeping  = 1'b0;
      sweep_idx = 0;
      last_rd   = '0;
      deg_m     = '0;
    end else begin
      w_ok = we_i && (wb_i < NB) && (wa_i < D) && !sweeping;
      e.wr_err = we_i && !w_ok;
      if (re_i) last_rd = ((rb_i < NB) && (ra_i < D)) ? model[rb_i][ra_i] : '0;
      e.rd_valid = re_i;
      if (w_ok) model[wb_i][wa_i] = wd_i;
      if (sweeping) begin
        for (int b = 0; b < NB; b++) model[b][sweep_idx] = '0;
        sweep_idx++;
        if (sweep_idx == D) sweeping = 1'b0;
      end else if (clr_i) begin
        sweeping  = 1'b1;
        sweep_idx = 0;
      end
      if (dwe_i) deg_m = din_i;
    end
    e.busy    = sweeping;
    e.rd_data = last_rd;
    e.deg_out = deg_m;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply_stimulus(1, 0, 0, 0, 0, '0, 0, 0, 0, 0, '0);
  endtask

  task automatic wr(input int b, input int a, input logic [W-1:0] d);
    apply_stimulus(1, 0, 1, b, a, d, 0, 0, 0, 0, '0);
  endtask

  task automatic rd(input int b, input int a);
    apply_stimulus(1, 0, 0, 0, 0, '0, 1, b, a, 0, '0);
  endtask

  task automatic fill_all();
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < D; a++)
        wr(b, a, W'($urandom) | W'(1));
  endtask

  task automatic read_all();
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < D; a++)
        rd(b, a);
  endtask

  task automatic check_output();
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    apply_stimulus(0, 0, 0, 0, 0, '0, 0, 0, 0, 0, '0);
    apply_stimulus(0, 0, 0, 0, 0, '0, 0, 0, 0, 0, '0);
    idle();

    wr(0, 5, 26'h3FFFFFF);
    wr(1, 5, 26'h0000123);
    rd(0, 5);
    rd(1, 5);
    idle();

    wr(0, 10, 26'd7);
    apply_stimulus(1, 0, 1, 0, 10, 26'd9, 1, 0, 10, 0, '0);
    rd(0, 10);
    idle();

    wr(0, 757, 26'h55);
    wr(1, 2047, 26'h55);
    rd(0, 757);
    rd(1, 2047);
    rd(0, 5);
    rd(1, 5);

    apply_stimulus(1, 0, 0, 0, 0, '0, 0, 0, 0, 1, 11'd756);
    repeat (3) idle();

    fill_all();
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(1, 0, 1'($urandom), int'($urandom_range(0, 1)),
                     int'($urandom_range(0, D + 20)), W'($urandom),
                     1'($urandom), int'($urandom_range(0, 1)),
                     int'($urandom_range(0, D + 20)),
                     ($urandom_range(0, 15) == 0), 11'($urandom));
    end

    // Write coincident with clr_start lands first, then the sweep erases it.
    apply_stimulus(1, 1, 1, 0, 3, 26'h77, 0, 0, 0, 0, '0);
    for (int i = 0; i < D; i++) begin
      apply_stimulus(1, 1'($urandom), 1'($urandom), int'($urandom_range(0, 1)),
                     int'($urandom_range(0, D - 1)), W'($urandom),
                     1'($urandom), int'($urandom_range(0, 1)),
                     int'($urandom_range(0, D - 1)), 0, '0);
    end
    repeat (2) idle();
    read_all();

    fill_all();
    apply_stimulus(1, 1, 0, 0, 0, '0, 0, 0, 0, 0, '0);
    repeat (100) idle();
    apply_stimulus(0, 0, 0, 0, 0, '0, 0, 0, 0, 0, '0);
    idle();
    read_all();

    apply_stimulus(1, 0, 0, 0, 0, '0, 0, 0, 0, 1, 11'd756);
    repeat (5) idle();
    wr(1, 756, 26'h1234567);
    rd(1, 756);
    idle();

    check_output();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
